// File: rtl/game_sequencer.sv
// Gameplay controller for the VGA obstacle game: menu/play/won/lost sequencing,
// obstacle scroll position, lap counting and the player jump profile.
//
// game state | meaning
// MENU       | title screen, datapath cleared, waiting for start
// PLAY       | obstacles scroll each frame_tick, jumps allowed, hit ends the run
// WON        | WIN_LAPS completed, datapath frozen until start
// LOST       | collision seen, datapath frozen until start
//
// jump state | meaning
// GROUND     | distance is 0, waiting for a jump edge
// RISE       | distance climbs JUMP_STEP per frame_tick up to JUMP_HEIGHT
// FALL       | distance drops JUMP_STEP per frame_tick down to 0
module game_sequencer #(
   parameter int SCROLL_STEP = 2,
   parameter int COURSE_LEN  = 680,
   parameter int WIN_LAPS    = 3,
   parameter int JUMP_HEIGHT = 60,
   parameter int JUMP_STEP   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       jump_btn,
   input  logic       hit,
   output logic       menu_screen,
   output logic       player_won,
   output logic       player_lost,
   output logic [9:0] distance,
   output logic [9:0] obj_counter,
   output logic [3:0] lap_count
);

   typedef enum logic [1:0] {MENU, PLAY, WON, LOST} game_t;
   typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;

   game_t       game_st;
   jump_t       jump_st;
   logic        start_q;
   logic        jump_q;
   logic        start_rise;
   logic        jump_rise;
   logic [10:0] scroll_sum;
   logic        wrap;
   logic [9:0]  obj_nxt;
   logic [3:0]  lap_nxt;
   logic        win_tick;
   logic [10:0] rise_sum;

   always_comb begin
      scroll_sum = {1'b0, obj_counter} + 11'(SCROLL_STEP);
      wrap       = (scroll_sum >= 11'(COURSE_LEN));
      obj_nxt    = wrap ? 10'(scroll_sum - 11'(COURSE_LEN)) : scroll_sum[9:0];
      lap_nxt    = lap_count;
      if (wrap && (lap_count != 4'd15))
         lap_nxt = lap_count + 4'd1;
      win_tick   = frame_tick & wrap & (lap_nxt >= 4'(WIN_LAPS));
      rise_sum   = {1'b0, distance} + 11'(JUMP_STEP);
   end

   // Rise pulses are registered so every button action lands one edge after the edge is seen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         game_st     <= MENU;
         jump_st     <= GROUND;
         start_q     <= 1'b0;
         jump_q      <= 1'b0;
         start_rise  <= 1'b0;
         jump_rise   <= 1'b0;
         menu_screen <= 1'b1;
         player_won  <= 1'b0;
         player_lost <= 1'b0;
         distance    <= '0;
         obj_counter <= '0;
         lap_count   <= '0;
      end else begin
         start_q    <= start_btn;
         jump_q     <= jump_btn;
         start_rise <= start_btn & ~start_q;
         jump_rise  <= jump_btn & ~jump_q;
         case (game_st)
            MENU: begin
               if (start_rise) begin
                  game_st     <= PLAY;
                  menu_screen <= 1'b0;
                  jump_st     <= GROUND;
                  distance    <= '0;
                  obj_counter <= '0;
                  lap_count   <= '0;
               end
            end
            PLAY: begin
               if (hit) begin
                  game_st     <= LOST;
                  player_lost <= 1'b1;
               end else begin
                  if (frame_tick) begin
                     obj_counter <= obj_nxt;
                     lap_count   <= lap_nxt;
                  end
                  if (win_tick) begin
                     game_st    <= WON;
                     player_won <= 1'b1;
                  end
                  case (jump_st)
                     GROUND: begin
                        if (jump_rise)
                           jump_st <= RISE;
                     end
                     RISE: begin
                        if (frame_tick) begin
                           if (rise_sum >= 11'(JUMP_HEIGHT)) begin
                              distance <= 10'(JUMP_HEIGHT);
                              jump_st  <= FALL;
                           end else begin
                              distance <= rise_sum[9:0];
                           end
                        end
                     end
                     FALL: begin
                        if (frame_tick) begin
                           if (distance <= 10'(JUMP_STEP)) begin
                              distance <= '0;
                              jump_st  <= GROUND;
                           end else begin
                              distance <= distance - 10'(JUMP_STEP);
                           end
                        end
                     end
                     default: jump_st <= GROUND;
                  endcase
               end
            end
            WON, LOST: begin
               if (start_rise) begin
                  game_st     <= MENU;
                  menu_screen <= 1'b1;
                  player_won  <= 1'b0;
                  player_lost <= 1'b0;
                  jump_st     <= GROUND;
                  distance    <= '0;
                  obj_counter <= '0;
                  lap_count   <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a position/lap reference model predicts
// every cycle's outputs, a monitor compares them after each rising edge.
module tb_game_sequencer;

   localparam int SCROLL_STEP = 2;
   localparam int COURSE_LEN  = 680;
   localparam int WIN_LAPS    = 3;
   localparam int JUMP_HEIGHT = 60;
   localparam int JUMP_STEP   = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       jump_btn = 1'b0;
   logic       hit = 1'b0;
   logic       menu_screen;
   logic       player_won;
   logic       player_lost;
   logic [9:0] distance;
   logic [9:0] obj_counter;
   logic [3:0] lap_count;

   int n_cmp = 0;
   int n_err = 0;
   logic [26:0] exp_q[$];

   game_sequencer #(
      .SCROLL_STEP(SCROLL_STEP), .COURSE_LEN(COURSE_LEN), .WIN_LAPS(WIN_LAPS),
      .JUMP_HEIGHT(JUMP_HEIGHT), .JUMP_STEP(JUMP_STEP)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
      .jump_btn(jump_btn), .hit(hit), .menu_screen(menu_screen), .player_won(player_won),
      .player_lost(player_lost), .distance(distance), .obj_counter(obj_counter),
      .lap_count(lap_count)
   );

   always #5 clk = ~clk;

   function automatic int laps_of(input int total);
      int l;
      l = total / COURSE_LEN;
      return (l > 15) ? 15 : l;
   endfunction

   // Reference model: phase 0 menu, 1 play, 2 won, 3 lost; the course is tracked
   // as total distance travelled, from which position and laps are derived.
   initial begin
      int  phase, total, height, jmode, old_laps;
      bit  s_prev, j_prev, s_pend, j_pend, act_s, act_j;
      phase = 0; total = 0; height = 0; jmode = 0;
      s_prev = 0; j_prev = 0; s_pend = 0; j_pend = 0;
      forever begin
         @(posedge clk);
         if (!reset) begin
            phase = 0; total = 0; height = 0; jmode = 0;
            s_prev = 0; j_prev = 0; s_pend = 0; j_pend = 0;
         end else begin
            act_s  = s_pend;
            act_j  = j_pend;
            s_pend = start_btn && !s_prev;
            j_pend = jump_btn && !j_prev;
            s_prev = start_btn;
            j_prev = jump_btn;
            if (phase == 1) begin
               if (hit) begin
                  phase = 3;
               end else begin
                  if (frame_tick) begin
                     old_laps = laps_of(total);
                     total += SCROLL_STEP;
                     if (laps_of(total) != old_laps && laps_of(total) >= WIN_LAPS)
                        phase = 2;
                  end
                  if (jmode == 0) begin
                     if (act_j) jmode = 1;
                  end else if (frame_tick) begin
                     if (jmode == 1) begin
                        height = (height + JUMP_STEP > JUMP_HEIGHT) ? JUMP_HEIGHT : height + JUMP_STEP;
                        if (height == JUMP_HEIGHT) jmode = 2;
                     end else begin
                        height = (height < JUMP_STEP) ? 0 : height - JUMP_STEP;
                        if (height == 0) jmode = 0;
                     end
                  end
               end
            end else if (act_s) begin
               phase  = (phase == 0) ? 1 : 0;
               total  = 0;
               height = 0;
               jmode  = 0;
            end
         end
         exp_q.push_back({phase == 0, phase == 2, phase == 3, 10'(height),
                          10'(total % COURSE_LEN), 4'(laps_of(total))});
      end
   end

   initial begin
      logic [26:0] exp_v, act_v;
      forever begin
         @(posedge clk);
         #1;
         act_v = {menu_screen, player_won, player_lost, distance, obj_counter, lap_count};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty t=%0t actual=%h", $time, act_v);
         end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
               n_err++;
               $display("FAIL outputs t=%0t actual menu/won/lost=%b%b%b dist=%0d obj=%0d lap=%0d required menu/won/lost=%b%b%b dist=%0d obj=%0d lap=%0d",
                        $time, act_v[26], act_v[25], act_v[24], act_v[23:14], act_v[13:4], act_v[3:0],
                        exp_v[26], exp_v[25], exp_v[24], exp_v[23:14], exp_v[13:4], exp_v[3:0]);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic j, input logic t, input logic h);
      @(negedge clk);
      start_btn  = s;
      jump_btn   = j;
      frame_tick = t;
      hit        = h;
   endtask

   task automatic press_start();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   initial begin
      logic s, j;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) cyc(0, 0, 1'(i % 2), 0);

      press_start();
      repeat (343) cyc(0, 0, 1, 0);

      for (int i = 0; i < 50; i++) cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);

      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      repeat (10) cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      repeat (50) cyc(0, 0, 1, 0);
      press_start();

      press_start();
      repeat (1019) cyc(0, 1'($urandom_range(0, 7) == 0), 1, 0);
      cyc(0, 0, 1, 0);
      repeat (20) cyc(0, 0, 1, 0);
      press_start();

      press_start();
      repeat (1019) cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      repeat (5) cyc(0, 0, 1, 0);
      press_start();

      press_start();
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      repeat (15) cyc(0, 0, 1, 0);
      @(negedge clk);
      start_btn = 0; jump_btn = 0; frame_tick = 0; hit = 0;
      reset = 1'b0;
      #1;
      check("async_reset_menu", int'(menu_screen), 1);
      check("async_reset_won", int'(player_won), 0);
      check("async_reset_lost", int'(player_lost), 0);
      check("async_reset_distance", int'(distance), 0);
      check("async_reset_obj", int'(obj_counter), 0);
      check("async_reset_lap", int'(lap_count), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      s = 0; j = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) s = ~s;
         if ($urandom_range(0, 5) == 0) j = ~j;
         cyc(s, j, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) == 0));
      end
      cyc(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level gameplay controller for the VGA obstacle game. It sequences the menu, play, won and lost phases.
- It owns the obstacle scroll counter and the player jump height.
- It drives the menu_screen/player_won/player_lost/distance/obj_counter inputs of the VGA video path, and consumes the registered collision hit flag.
- All motion advances on a one-cycle frame_tick strobe derived from the frame timing.

Parameters:
- SCROLL_STEP, 2, obj_counter increment per frame_tick in PLAY
- COURSE_LEN, 680, obj_counter wrap value; one wrap = one lap
- WIN_LAPS, 3, laps required to win (1..15)
- JUMP_HEIGHT, 60, peak distance in pixels
- JUMP_STEP, 3, distance change per frame_tick while airborne

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-low reset (0 = reset asserted)
- frame_tick, input, 1, one-cycle pulse per video frame
- start_btn, input, 1, start/restart button level, already synchronised
- jump_btn, input, 1, jump button level, already synchronised
- hit, input, 1, collision flag from the video path; sampled only in PLAY
- menu_screen, output, 1, high in MENU
- player_won, output, 1, high in WON
- player_lost, output, 1, high in LOST
- distance, output, 10, player height above ground in pixels
- obj_counter, output, 10, obstacle scroll position
- lap_count, output, 4, completed laps

Behaviour:
- Reset (reset=0, async): state=MENU, menu_screen=1, player_won=0, player_lost=0, distance=0, obj_counter=0, lap_count=0, jump FSM=GROUND, button history regs=0.
- All outputs are registered. Status flags decode directly from state registers.
- Button edges:
  - start_rise = start_btn & ~start_q; jump_rise = jump_btn & ~jump_q.
  - start_q and jump_q are the previous-cycle levels.
  - An action occurs on the clock edge after the cycle in which the rise is seen (1-cycle latency).
  - A held button never re-triggers.
- Game FSM:
  - MENU -> PLAY on start_rise. On entry: obj_counter=0, lap_count=0, distance=0, jump=GROUND.
  - PLAY -> LOST on hit=1 (any cycle, not just frame_tick).
  - PLAY -> WON when a frame_tick wrap makes lap_count reach WIN_LAPS.
  - If hit=1 coincides with the winning wrap tick, LOST wins.
  - WON/LOST -> MENU on start_rise. distance, obj_counter and lap_count stay frozen until MENU is entered; entering MENU clears them.
  - frame_tick and jump_btn are ignored outside PLAY.
- Scroll (PLAY, frame_tick):
  - nxt = obj_counter + SCROLL_STEP, computed 11 bits wide.
  - If nxt >= COURSE_LEN: obj_counter = nxt - COURSE_LEN and lap_count increments (saturates at 15).
  - Otherwise obj_counter = nxt.
- Jump FSM (PLAY only), states GROUND, RISE, FALL:
  - GROUND -> RISE on jump_rise. distance is unchanged until the next frame_tick.
  - RISE on frame_tick: distance += JUMP_STEP. If the result >= JUMP_HEIGHT, clamp to JUMP_HEIGHT and go to FALL.
  - FALL on frame_tick: if distance <= JUMP_STEP, set distance=0 and go to GROUND; otherwise distance -= JUMP_STEP.
  - jump_rise in RISE/FALL is ignored (no double jump, no buffering).
  - jump_rise and frame_tick in the same GROUND cycle: enter RISE; the first rise step occurs on the next frame_tick.
- distance never exceeds JUMP_HEIGHT and never underflows.
- Reset mid-game returns everything to the reset values immediately, with no pending edges retained.

Test Plan:
1. Release reset, no stimulus, run 10 frame_ticks -> menu_screen=1, obj_counter=0, distance=0, lap_count=0.
2. Start and scroll:
   - Pulse start_btn for 1 cycle -> menu_screen=0 two edges later.
   - 340 frame_ticks with SCROLL_STEP=2 -> obj_counter=0, lap_count=1.
   - 3 more ticks -> obj_counter=6.
3. Jump profile:
   - In PLAY, pulse jump_btn, then 20 frame_ticks -> distance 3,6,...,60 (20th tick), state FALL.
   - 20 more ticks -> distance 0, GROUND.
   - jump_btn held high throughout -> exactly one jump.
4. Collision: in PLAY with distance=30, assert hit for 1 cycle -> player_lost=1 next edge. distance stays 30 and obj_counter is frozen across 50 ticks.
5. Win and hit tie:
   - Drive to lap_count=2 with obj_counter=678, then frame_tick -> player_won=1, lap_count=3.
   - Repeat the same tick with hit=1 -> player_lost=1, player_won=0.
6. Restart and reset:
   - From WON, pulse start_btn -> MENU with outputs cleared.
   - Start again, then drive reset=0 mid-jump -> all outputs at reset values asynchronously.
